vec_split_stream: RTL and testbench

Splits a continuous stream of densely packed fixed-width vectors into per-vector bus words. Each vector begins on a fresh output word, and its final sub-vector is zero-padded on the LSB side. Compared with the previous separator generation it adds:
- full AXI-style backpressure on both sides, using a 2-word bit accumulator;
- a sub-vector index output;
- batch-end drain that discards trailing word padding;
- restart of vector IDs per batch;
- an underrun error flag.

It sits between the host input FIFO and the popcount/compare pipeline.

---
 rtl/vec_split_stream_if.sv | 29 ++
 rtl/vec_split_stream.sv | 151 +++++++++++++++
 tb/tb_vec_split_stream.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_split_stream_if.sv
// Handshake bundle for vec_split_stream: upstream word stream in, per-vector
// sub-vector words out. The slave modport is the splitter's view; master is
// the surrounding environment (host FIFO on one side, popcount on the other).
interface vec_split_stream_if #(
  parameter int BUS_WIDTH    = 128,
  parameter int VEC_ID_WIDTH = 8,
  parameter int SUB_IDX_W    = 4
);
  logic [BUS_WIDTH-1:0]    up_Vector;
  logic                    up_Valid;
  logic                    up_Last;
  logic                    up_Ready;
  logic [BUS_WIDTH-1:0]    dn_Vector;
  logic [VEC_ID_WIDTH-1:0] dn_VecID;
  logic [SUB_IDX_W-1:0]    dn_SubIdx;
  logic                    dn_Valid;
  logic                    dn_Last;
  logic                    dn_Ready;

  modport slave (
    input  up_Vector, up_Valid, up_Last, dn_Ready,
    output up_Ready, dn_Vector, dn_VecID, dn_SubIdx, dn_Valid, dn_Last
  );

  modport master (
    output up_Vector, up_Valid, up_Last, dn_Ready,
    input  up_Ready, dn_Vector, dn_VecID, dn_SubIdx, dn_Valid, dn_Last
  );
endinterface

// File: rtl/vec_split_stream.sv
// Splits a densely packed vector stream into per-vector bus words. Bits are
// collected in a 2-word MSB-aligned accumulator; each vector starts on a
// fresh output word and its last sub-vector is zero-padded on the LSB side.
// At batch end the trailing word padding is dropped and vector IDs restart.
module vec_split_stream #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int VEC_ID_WIDTH = 8,
  parameter int REVERSE_BITS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  vec_split_stream_if.slave bus,
  output logic              err_Underrun
);
  localparam int SUB_VEC_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int DELTA      = SUB_VEC_NO * BUS_WIDTH - VECTOR_WIDTH;
  localparam int SUB_IDX_W  = $clog2(SUB_VEC_NO) + 1;
  localparam int ACC_W      = 2 * BUS_WIDTH;
  localparam int FILL_W     = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0]    FULL_NEED = FILL_W'(BUS_WIDTH);
  localparam logic [FILL_W-1:0]    PAD_NEED  = FILL_W'(BUS_WIDTH - DELTA);
  localparam logic [BUS_WIDTH-1:0] PAD_MASK  = {BUS_WIDTH{1'b1}} << DELTA;
  localparam logic [SUB_IDX_W-1:0] LAST_SUB  = SUB_IDX_W'(SUB_VEC_NO - 1);
  localparam logic [31:0]          VW32      = 32'(VECTOR_WIDTH);
  localparam logic [VEC_ID_WIDTH-1:0] ID_FIRST = VEC_ID_WIDTH'(1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [SUB_IDX_W-1:0]    sub_q, sub_d;
  logic [VEC_ID_WIDTH-1:0] id_q, id_d;
  logic                    err_q, err_d;

  logic [BUS_WIDTH-1:0]    w_in;
  logic [BUS_WIDTH-1:0]    top;
  logic [FILL_W-1:0]       need, pop_amt, fill_pop;
  logic [ACC_W-1:0]        acc_pop;
  logic [31:0]             fill32, rem32;
  logic                    is_pad, in_drain, flush_end, underrun, discard;
  logic                    dn_valid, up_ready, up_fire, dn_fire;

  // Optional per-bit reversal so software byte order lands MSB-first.
  generate
    if (REVERSE_BITS != 0) begin : g_rev
      for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
        assign w_in[i] = bus.up_Vector[BUS_WIDTH-1-i];
      end
    end else begin : g_pass
      assign w_in = bus.up_Vector;
    end
  endgenerate

  // The pad word of a vector only consumes the bits the vector still owns.
  assign is_pad   = (sub_q == LAST_SUB);
  assign need     = is_pad ? PAD_NEED : FULL_NEED;
  assign in_drain = (state_q == DRAIN);
  assign fill32   = 32'(fill_q);
  assign rem32    = 32'(fill_q - need);

  // Batch end: whatever is left at a vector boundary is word padding.
  assign flush_end = in_drain && (sub_q == '0) && (fill32 < VW32);
  // Batch ended mid-vector: the vector can never complete.
  assign underrun  = in_drain && (sub_q != '0) && (fill_q < need);
  assign discard   = flush_end || underrun;

  // Leftover padding is never presented as data while it is being dropped.
  assign dn_valid = (fill_q >= need) && !discard;
  assign up_ready = (fill_q <= FULL_NEED) && !in_drain;
  assign up_fire  = bus.up_Valid && up_ready;
  assign dn_fire  = dn_valid && bus.dn_Ready;

  assign pop_amt  = dn_fire ? need : '0;
  assign acc_pop  = acc_q << pop_amt;
  assign fill_pop = fill_q - pop_amt;

  // Bits below fill are always zero, so unfilled bits read back as zero.
  assign top = acc_q[ACC_W-1 -: BUS_WIDTH];

  assign bus.up_Ready  = up_ready;
  assign bus.dn_Valid  = dn_valid;
  assign bus.dn_Vector = is_pad ? (top & PAD_MASK) : top;
  assign bus.dn_VecID  = id_q;
  assign bus.dn_SubIdx = sub_q;
  assign bus.dn_Last   = dn_valid && in_drain && is_pad && (rem32 < VW32);
  assign err_Underrun  = err_q;

  // Next state: enter DRAIN on the last input word, leave after the discard.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (up_fire && bus.up_Last) state_d = DRAIN;
      DRAIN:   if (discard)                state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Accumulator, counters and error flag; pop and push apply together.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    sub_d  = sub_q;
    id_d   = id_q;
    err_d  = err_q;
    if (discard) begin
      acc_d  = '0;
      fill_d = '0;
      sub_d  = '0;
      id_d   = ID_FIRST;
      err_d  = err_q || underrun;
    end else begin
      acc_d  = acc_pop;
      fill_d = fill_pop;
      if (up_fire) begin
        acc_d  = acc_pop | ({w_in, {BUS_WIDTH{1'b0}}} >> fill_pop);
        fill_d = fill_pop + FULL_NEED;
      end
      if (dn_fire) begin
        sub_d = is_pad ? '0 : sub_q + 1'b1;
        if (is_pad)
          id_d = (id_q == {VEC_ID_WIDTH{1'b1}}) ? ID_FIRST : id_q + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      fill_q <= '0;
      sub_q  <= '0;
      id_q   <= ID_FIRST;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      sub_q  <= sub_d;
      id_q   <= id_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_vec_split_stream.sv
// Cycle-accurate directed bench for vec_split_stream. Four configurations
// share one input stream; a selector picks which one each row checks.
//   a: BW=8 VW=12 rev=0 id=8   b: BW=8 VW=16 rev=1
//   c: BW=8 VW=12 id=2 (wrap)  d: BW=8 VW=20 (underrun reachable)
module tb_vec_split_stream;
  logic       clk = 1'b0;
  logic       rstn;
  logic       uv, ulast, dr;
  logic [7:0] uvec;
  logic [1:0] sel;
  logic       err_a, err_b, err_c, err_d;

  logic       chk_upr, chk_dv, chk_last, chk_err;
  logic [7:0] chk_dvec, chk_id;
  logic [2:0] chk_sub;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vec_split_stream_if #(.BUS_WIDTH(8), .VEC_ID_WIDTH(8), .SUB_IDX_W(2)) ifa ();
  vec_split_stream_if #(.BUS_WIDTH(8), .VEC_ID_WIDTH(8), .SUB_IDX_W(2)) ifb ();
  vec_split_stream_if #(.BUS_WIDTH(8), .VEC_ID_WIDTH(2), .SUB_IDX_W(2)) ifc ();
  vec_split_stream_if #(.BUS_WIDTH(8), .VEC_ID_WIDTH(8), .SUB_IDX_W(3)) ifd ();

  assign ifa.up_Vector = uvec; assign ifa.up_Valid = uv; assign ifa.up_Last = ulast; assign ifa.dn_Ready = dr;
  assign ifb.up_Vector = uvec; assign ifb.up_Valid = uv; assign ifb.up_Last = ulast; assign ifb.dn_Ready = dr;
  assign ifc.up_Vector = uvec; assign ifc.up_Valid = uv; assign ifc.up_Last = ulast; assign ifc.dn_Ready = dr;
  assign ifd.up_Vector = uvec; assign ifd.up_Valid = uv; assign ifd.up_Last = ulast; assign ifd.dn_Ready = dr;

  vec_split_stream #(.BUS_WIDTH(8), .VECTOR_WIDTH(12), .VEC_ID_WIDTH(8), .REVERSE_BITS(0))
    dut_a (.clk(clk), .rstn(rstn), .bus(ifa), .err_Underrun(err_a));
  vec_split_stream #(.BUS_WIDTH(8), .VECTOR_WIDTH(16), .VEC_ID_WIDTH(8), .REVERSE_BITS(1))
    dut_b (.clk(clk), .rstn(rstn), .bus(ifb), .err_Underrun(err_b));
  vec_split_stream #(.BUS_WIDTH(8), .VECTOR_WIDTH(12), .VEC_ID_WIDTH(2), .REVERSE_BITS(0))
    dut_c (.clk(clk), .rstn(rstn), .bus(ifc), .err_Underrun(err_c));
  vec_split_stream #(.BUS_WIDTH(8), .VECTOR_WIDTH(20), .VEC_ID_WIDTH(8), .REVERSE_BITS(0))
    dut_d (.clk(clk), .rstn(rstn), .bus(ifd), .err_Underrun(err_d));

  // Route the selected instance onto common check signals.
  always_comb begin
    chk_upr = 1'b0; chk_dv = 1'b0; chk_dvec = 8'h00; chk_id = 8'h00;
    chk_sub = 3'd0; chk_last = 1'b0; chk_err = 1'b0;
    case (sel)
      2'd0: begin
        chk_upr = ifa.up_Ready; chk_dv = ifa.dn_Valid; chk_dvec = ifa.dn_Vector;
        chk_id = ifa.dn_VecID; chk_sub = 3'(ifa.dn_SubIdx); chk_last = ifa.dn_Last; chk_err = err_a;
      end
      2'd1: begin
        chk_upr = ifb.up_Ready; chk_dv = ifb.dn_Valid; chk_dvec = ifb.dn_Vector;
        chk_id = ifb.dn_VecID; chk_sub = 3'(ifb.dn_SubIdx); chk_last = ifb.dn_Last; chk_err = err_b;
      end
      2'd2: begin
        chk_upr = ifc.up_Ready; chk_dv = ifc.dn_Valid; chk_dvec = ifc.dn_Vector;
        chk_id = 8'(ifc.dn_VecID); chk_sub = 3'(ifc.dn_SubIdx); chk_last = ifc.dn_Last; chk_err = err_c;
      end
      default: begin
        chk_upr = ifd.up_Ready; chk_dv = ifd.dn_Valid; chk_dvec = ifd.dn_Vector;
        chk_id = ifd.dn_VecID; chk_sub = ifd.dn_SubIdx; chk_last = ifd.dn_Last; chk_err = err_d;
      end
    endcase
  end

  typedef struct {
    logic       rst;
    logic [1:0] sel;
    logic       uv;
    logic [7:0] uvec;
    logic       ulast;
    logic       dr;
    logic       e_upr;
    logic       e_dv;
    logic [7:0] e_dvec;
    logic [7:0] e_id;
    logic [2:0] e_sub;
    logic       e_last;
    logic       e_err;
  } row_t;

  row_t tbl[$];

  task automatic add(input bit r, input int s, input bit v, input int vec, input bit l,
                     input bit d, input bit eu, input bit ev, input int evec, input int eid,
                     input int esub, input bit el, input bit ee);
    row_t x;
    x.rst = r; x.sel = 2'(s); x.uv = v; x.uvec = 8'(vec); x.ulast = l; x.dr = d;
    x.e_upr = eu; x.e_dv = ev; x.e_dvec = 8'(evec); x.e_id = 8'(eid);
    x.e_sub = 3'(esub); x.e_last = el; x.e_err = ee;
    tbl.push_back(x);
  endtask

  // Packed compare: {upR, dv, vec, id, sub, last, err}.
  task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got upR=%b dv=%b vec=%h id=%0d sub=%0d last=%b err=%b, want upR=%b dv=%b vec=%h id=%0d sub=%0d last=%b err=%b",
               nm, got[22], got[21], got[20:13], got[12:5], got[4:2], got[1], got[0],
               exp[22], exp[21], exp[20:13], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [22:0] now_vals(input logic mask_vec);
    return {chk_upr, chk_dv, (mask_vec ? chk_dvec : 8'h00), chk_id, chk_sub, chk_last, chk_err};
  endfunction

  localparam logic [22:0] RESET_VALS = {1'b1, 1'b0, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0};

  task automatic idle();
    uv = 1'b0; uvec = 8'h00; ulast = 1'b0; dr = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drive one row at a negedge, check just before the next posedge.
  task automatic apply_row(input int i);
    sel = tbl[i].sel; uv = tbl[i].uv; uvec = tbl[i].uvec; ulast = tbl[i].ulast; dr = tbl[i].dr;
    #2;
    chk($sformatf("row%0d", i), now_vals(tbl[i].e_dv),
        {tbl[i].e_upr, tbl[i].e_dv, tbl[i].e_dvec, tbl[i].e_id, tbl[i].e_sub, tbl[i].e_last, tbl[i].e_err});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rst sel | uv vec last dr | upR dv vec id sub last err
    // a: three words, two vectors, batch drain (rows 0..6)
    add(1,0, 1,'hAB,0,1, 1,0,'h00,1,0,0,0);
    add(0,0, 1,'hC1,0,1, 1,1,'hAB,1,0,0,0);
    add(0,0, 1,'h23,1,1, 1,1,'hC0,1,1,0,0);
    add(0,0, 0,'h00,0,1, 0,1,'h12,2,0,0,0);
    add(0,0, 0,'h00,0,1, 0,1,'h30,2,1,1,0);
    add(0,0, 0,'h00,0,1, 0,0,'h00,3,0,0,0);
    add(0,0, 0,'h00,0,1, 1,0,'h00,1,0,0,0);
    // a: trailing 4 bits discarded, IDs restart
    add(0,0, 1,'hAB,0,1, 1,0,'h00,1,0,0,0);
    add(0,0, 1,'hC5,1,1, 1,1,'hAB,1,0,0,0);
    add(0,0, 0,'h00,0,1, 0,1,'hC0,1,1,1,0);
    add(0,0, 0,'h00,0,1, 0,0,'h00,2,0,0,0);
    add(0,0, 0,'h00,0,1, 1,0,'h00,1,0,0,0);
    // a: first stream with dn_Ready 1,0,0,1,... (stall hold, up_Ready low at fill 16)
    add(0,0, 1,'hAB,0,1, 1,0,'h00,1,0,0,0);
    add(0,0, 1,'hC1,0,0, 1,1,'hAB,1,0,0,0);
    add(0,0, 1,'h23,1,0, 0,1,'hAB,1,0,0,0);
    add(0,0, 1,'h23,1,1, 0,1,'hAB,1,0,0,0);
    add(0,0, 1,'h23,1,1, 1,1,'hC0,1,1,0,0);
    add(0,0, 0,'h00,0,0, 0,1,'h12,2,0,0,0);
    add(0,0, 0,'h00,0,0, 0,1,'h12,2,0,0,0);
    add(0,0, 0,'h00,0,1, 0,1,'h12,2,0,0,0);
    add(0,0, 0,'h00,0,1, 0,1,'h30,2,1,1,0);
    add(0,0, 0,'h00,0,0, 0,0,'h00,3,0,0,0);
    add(0,0, 0,'h00,0,0, 1,0,'h00,1,0,0,0);
    // b: bit reversal, DELTA=0 full pad word
    add(1,1, 1,'h01,0,1, 1,0,'h00,1,0,0,0);
    add(0,1, 1,'h0E,1,1, 1,1,'h80,1,0,0,0);
    add(0,1, 0,'h00,0,1, 0,1,'h70,1,1,1,0);
    add(0,1, 0,'h00,0,1, 0,0,'h00,2,0,0,0);
    add(0,1, 0,'h00,0,1, 1,0,'h00,1,0,0,0);
    // c: four vectors, 2-bit ID wraps 3 -> 1
    add(1,2, 1,'h12,0,1, 1,0,'h00,1,0,0,0);
    add(0,2, 1,'h34,0,1, 1,1,'h12,1,0,0,0);
    add(0,2, 1,'h56,0,1, 1,1,'h30,1,1,0,0);
    add(0,2, 1,'h78,0,1, 0,1,'h45,2,0,0,0);
    add(0,2, 1,'h78,0,1, 1,1,'h60,2,1,0,0);
    add(0,2, 1,'h9A,0,1, 1,1,'h78,3,0,0,0);
    add(0,2, 1,'hBC,1,1, 1,1,'h90,3,1,0,0);
    add(0,2, 0,'h00,0,1, 0,1,'hAB,1,0,0,0);
    add(0,2, 0,'h00,0,1, 0,1,'hC0,1,1,1,0);
    add(0,2, 0,'h00,0,1, 0,0,'h00,2,0,0,0);
    add(0,2, 0,'h00,0,1, 1,0,'h00,1,0,0,0);
    // d: batch ends mid-vector -> sticky underrun, no dn_Last
    add(1,3, 1,'h11,0,1, 1,0,'h00,1,0,0,0);
    add(0,3, 1,'h22,1,1, 1,1,'h11,1,0,0,0);
    add(0,3, 0,'h00,0,1, 0,1,'h22,1,1,0,0);
    add(0,3, 0,'h00,0,1, 0,0,'h00,1,2,0,0);
    add(0,3, 0,'h00,0,1, 1,0,'h00,1,0,0,1);
    add(0,3, 1,'h33,0,1, 1,0,'h00,1,0,0,1);
    add(0,3, 0,'h00,0,1, 1,1,'h33,1,0,0,1);

    rstn = 1'b0;
    sel = 2'd0;
    idle();
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("reset_dut%0d", s), now_vals(1'b1), RESET_VALS);
    end
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply_row(i);
    end

    // Asynchronous reset mid-vector, then the first stream again from scratch.
    do_reset();
    apply_row(0);
    apply_row(1);
    uv = 1'b0;
    #1;
    chk("mid_vector", now_vals(1'b1), {1'b1, 1'b1, 8'hC0, 8'h01, 3'd1, 1'b0, 1'b0});
    rstn = 1'b0;
    #1;
    chk("async_reset", now_vals(1'b1), RESET_VALS);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) apply_row(i);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
